if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  6  pipeline stall vector; bit0 = PC/fetch stage, bit1 = IF/ID register.
REQ-005 ex_b_flag  input  1  redirect request from EX.
REQ-006 ex_b_target  input  32  redirect target from EX.
REQ-007 id_b_flag  input  1  redirect request from ID.
REQ-008 id_b_target  input  32  redirect target from ID.
REQ-009 mem_req  output  1  instruction-memory request, level, held until acknowledged.
REQ-010 mem_addr  output  32  word address of outstanding request.
REQ-011 mem_ack  input  1  one-cycle pulse; mem_rdata valid in that cycle.
REQ-012 mem_rdata  input  32  fetched instruction.
REQ-013 if_pc  output  32  PC of presented instruction, ZeroWord when none.
REQ-014 if_inst  output  32  presented instruction, ZeroWord (bubble) when none.
REQ-015 stallreq_if  output  1  fetch-not-complete stall request to stall controller.

Function
REQ-016 Block SHALL implement FSM with states IDLE, WAIT, HOLD, DISCARD.
REQ-017 IDLE, stall[0]=0, no redirect: SHALL assert mem_req with mem_addr=pc and enter WAIT next cycle; stall[0]=1: SHALL stay IDLE, mem_req=0.
REQ-018 WAIT: mem_req=1 and mem_addr SHALL stay constant until the mem_ack cycle inclusive; mem_req SHALL drop the cycle after.
REQ-019 WAIT with mem_ack and no redirect: SHALL capture if_pc<=pc, if_inst<=mem_rdata, pc<=pc+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0); next state HOLD if stall[1]=1 else IDLE.
REQ-020 Fetch latency SHALL be: request issued cycle N, ack earliest cycle N+1, outputs valid from edge ending ack cycle.
REQ-021 Captured outputs SHALL hold while stall[1]=1 (state HOLD, no new request issued); at first edge with stall[1]=0 the block SHALL clear if_pc/if_inst to ZeroWord and go IDLE, so IF/ID samples the instruction exactly once.
REQ-022 Outputs SHALL otherwise be ZeroWord; a valid instruction is never presented for more than one unstalled edge.
REQ-023 Redirect: when ex_b_flag or id_b_flag is 1, pc SHALL load target with [1:0] forced to 2'b00; ex_b_target SHALL win when both asserted.
REQ-024 Redirect SHALL clear if_pc/if_inst at same edge and discard any held or arriving instruction.
REQ-025 Redirect in WAIT without mem_ack SHALL enter DISCARD; with mem_ack same cycle SHALL drop rdata and enter IDLE; in HOLD SHALL enter IDLE.
REQ-026 DISCARD: mem_req/mem_addr SHALL stay as issued; on mem_ack data dropped, state IDLE; further redirects SHALL only update pc.
REQ-027 stallreq_if SHALL be 1 exactly in WAIT and DISCARD.
REQ-028 Redirect SHALL take effect regardless of stall bits.

Reset
REQ-029 rst=1 SHALL asynchronously force pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=ZeroWord, if_pc=ZeroWord, if_inst=ZeroWord, stallreq_if=0.
REQ-030 Reset during WAIT/DISCARD SHALL abandon the request; an mem_ack arriving after deassertion while in IDLE SHALL be ignored.
REQ-031 First request SHALL issue in first cycle after rst deasserts with stall[0]=0.

Structure
REQ-032 Bus widths, ZeroWord and stall-bit indices SHALL come from shared Defines.vh; FSM encoding SHALL be local to the module.
REQ-033 Next-PC selection (pc+4, ex target, id target, alignment) SHALL be a combinational sub-module if_pc_gen.

Verification
REQ-034 Reset then ack one cycle after each request, rdata=32'h0000_0013: mem_addr 0,4,8 issued; if_inst=32'h13 with if_pc 0,4,8 each for one cycle.
REQ-035 stall[1]=1 for 3 cycles after ack at pc=4: if_pc=4 held 3 cycles, mem_req=0 throughout, then cleared.
REQ-036 ex_b_flag=1, target 32'h0000_0103, while WAIT with ack 2 cycles later: DISCARD, late rdata dropped, next mem_addr=32'h100.
REQ-037 ex_b_flag and id_b_flag same cycle, targets 32'h200/32'h300: next mem_addr=32'h200.
REQ-038 pc=32'hFFFF_FFFC fetched: next mem_addr=32'h0.
REQ-039 rst asserted mid-WAIT, ack after release: outputs ZeroWord, first mem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, ZeroWord, stall-bit indices and the PC alignment helper for the fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_DATA_W = 32;
  localparam int unsigned STALL_W     = 6;

  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = INST_ADDR_W'(0);
  localparam logic [INST_DATA_W-1:0] ZERO_INST = INST_DATA_W'(0);
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = INST_ADDR_W'(4);

  // Redirect targets are word addresses; the low byte-offset bits are dropped.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Combinational next-PC selection: sequential pc+4 and the aligned redirect target (EX over ID).
module if_pc_gen
  import if_fetch_pkg::*;
(
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   ex_b_flag,
  input  logic [INST_ADDR_W-1:0] ex_b_target,
  input  logic                   id_b_flag,
  input  logic [INST_ADDR_W-1:0] id_b_target,
  output logic [INST_ADDR_W-1:0] pc_seq_c,
  output logic                   redirect_c,
  output logic [INST_ADDR_W-1:0] redirect_pc_c
);

  assign pc_seq_c      = pc + PC_STEP;
  assign redirect_c    = ex_b_flag | id_b_flag;
  assign redirect_pc_c = word_align(ex_b_flag ? ex_b_target : id_b_target);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one memory request at a time and presents each fetched
// instruction to IF/ID exactly once, dropping anything overtaken by a redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   ex_b_flag,
  input  logic [INST_ADDR_W-1:0] ex_b_target,
  input  logic                   id_b_flag,
  input  logic [INST_ADDR_W-1:0] id_b_target,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [INST_DATA_W-1:0] mem_rdata,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_DATA_W-1:0] if_inst,
  output logic                   stallreq_if
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;

  state_t                   state;
  logic [INST_ADDR_W-1:0]   pc;
  logic [INST_ADDR_W-1:0]   pc_seq_c;
  logic                     redirect_c;
  logic [INST_ADDR_W-1:0]   redirect_pc_c;
  logic                     unused_stall_c;

  // Only the PC and IF/ID stall bits matter to this stage.
  assign unused_stall_c = ^stall[STALL_W-1:2];

  if_pc_gen u_pc_gen (
    .pc            (pc),
    .ex_b_flag     (ex_b_flag),
    .ex_b_target   (ex_b_target),
    .id_b_flag     (id_b_flag),
    .id_b_target   (id_b_target),
    .pc_seq_c      (pc_seq_c),
    .redirect_c    (redirect_c),
    .redirect_pc_c (redirect_pc_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= ZERO_WORD;
      if_pc       <= ZERO_WORD;
      if_inst     <= ZERO_INST;
      stallreq_if <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A presented instruction lives for one edge only.
          if_pc   <= ZERO_WORD;
          if_inst <= ZERO_INST;
          if (redirect_c) begin
            pc <= redirect_pc_c;
          end else if (!stall[STALL_PC]) begin
            mem_req     <= 1'b1;
            mem_addr    <= pc;
            stallreq_if <= 1'b1;
            state       <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_c) begin
            pc      <= redirect_pc_c;
            if_pc   <= ZERO_WORD;
            if_inst <= ZERO_INST;
            if (mem_ack) begin
              mem_req     <= 1'b0;
              stallreq_if <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DISCARD;
            end
          end else if (mem_ack) begin
            if_pc       <= pc;
            if_inst     <= mem_rdata;
            pc          <= pc_seq_c;
            mem_req     <= 1'b0;
            stallreq_if <= 1'b0;
            state       <= stall[STALL_IFID] ? HOLD : IDLE;
          end
        end

        HOLD: begin
          if (redirect_c || !stall[STALL_IFID]) begin
            if (redirect_c) begin
              pc <= redirect_pc_c;
            end
            if_pc   <= ZERO_WORD;
            if_inst <= ZERO_INST;
            state   <= IDLE;
          end
        end

        DISCARD: begin
          // Request stays on the bus until memory answers; the answer is thrown away.
          if (redirect_c) begin
            pc <= redirect_pc_c;
          end
          if (mem_ack) begin
            mem_req     <= 1'b0;
            stallreq_if <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch with a transaction-level fetch model.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        ex_b_flag = 1'b0;
  logic [31:0] ex_b_target = '0;
  logic        id_b_flag = 1'b0;
  logic [31:0] id_b_target = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_b_flag   (ex_b_flag),
    .ex_b_target (ex_b_target),
    .id_b_flag   (id_b_flag),
    .id_b_target (id_b_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .stallreq_if (stallreq_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_samples = 0;

  // Reference model: program counter, the one outstanding request, the one presented instruction.
  logic [31:0] m_pc = RESET_PC;
  bit          out_v = 0, out_taint = 0, pend_v = 0, just_acked = 0;
  logic [31:0] out_addr = '0, pend_pc = '0, pend_inst = '0, last_req_addr = '0;
  int          out_age = 0, out_lat = 1, hold_cnt = 0, req_cnt = 0;

  // Stimulus controls.
  bit          rnd = 0, no_ack = 0, f_ex = 0, f_id = 0;
  int          f_lat = 1, f_hold = 0;
  logic [31:0] f_ex_t = '0, f_id_t = '0;

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  task automatic step();
    logic        ack, ex_f, id_f, s1, redir, keep;
    logic [31:0] rdata, ex_t, id_t, tgt;
    logic [5:0]  st;
    int          k;
    @(posedge clk); #1;
    if (just_acked) begin
      chk(!mem_req, "req_drop", 32'(mem_req), 32'h0);
    end else if (out_v) begin
      out_age++;
      chk(mem_req && mem_addr == out_addr, "req_hold", mem_addr, out_addr);
    end else if (mem_req) begin
      chk(!pend_v, "req_while_presenting", mem_addr, 32'h0);
      chk(mem_addr == m_pc, "req_addr", mem_addr, m_pc);
      out_v = 1; out_addr = mem_addr; out_age = 0; out_taint = 0;
      out_lat = rnd ? int'($urandom_range(1, 3)) : f_lat;
      req_cnt++; last_req_addr = mem_addr;
    end
    just_acked = 0;
    chk(stallreq_if == out_v, "stallreq", 32'(stallreq_if), 32'(out_v));
    if (pend_v) chk(if_pc == pend_pc && if_inst == pend_inst, "present_hold", if_pc, pend_pc);
    else        chk(if_pc == 32'h0 && if_inst == 32'h0, "bubble", if_inst, 32'h0);

    ack   = out_v && !no_ack && (out_age >= out_lat);
    rdata = ack ? (rnd ? ($urandom | 32'h1) : 32'h0000_0013) : $urandom;
    ex_f  = f_ex || (rnd && $urandom_range(0, 11) == 0);
    id_f  = f_id || (rnd && $urandom_range(0, 11) == 0);
    ex_t  = f_ex ? f_ex_t : 32'($urandom_range(0, 32'h3ff));
    id_t  = f_id ? f_id_t : 32'($urandom_range(0, 32'h3ff));
    redir = ex_f || id_f;
    tgt   = ex_f ? ex_t : id_t;
    tgt[1:0] = 2'b00;
    keep  = ack && !out_taint && !redir;
    if (hold_cnt > 0) begin
      s1 = 1'b1; hold_cnt--;
    end else if (keep) begin
      k = rnd ? int'($urandom_range(0, 3)) : f_hold;
      s1 = (k > 0);
      hold_cnt = (k > 0) ? k - 1 : 0;
    end else begin
      s1 = rnd && !pend_v && ($urandom_range(0, 3) == 0);
    end
    st = rnd ? 6'($urandom) : 6'h0;
    st[0] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    st[1] = s1;

    mem_ack = ack; mem_rdata = rdata; stall = st;
    ex_b_flag = ex_f; ex_b_target = ex_t; id_b_flag = id_f; id_b_target = id_t;

    // Effect of the coming edge.
    if (pend_v) begin
      if (!s1) begin exp_q.push_back('{pc: pend_pc, inst: pend_inst}); pend_v = 0; end
      else if (redir) pend_v = 0;
    end
    if (ack) begin
      if (keep) begin
        pend_v = 1; pend_pc = out_addr; pend_inst = rdata; m_pc = out_addr + 32'd4;
      end
      out_v = 0; just_acked = 1;
    end
    if (redir) begin
      m_pc = tgt;
      if (out_v) out_taint = 1;
    end
  endtask

  task automatic wait_req();
    int c0 = req_cnt;
    for (int i = 0; i < 40 && req_cnt == c0; i++) step();
    chk(req_cnt != c0, "req_timeout", 32'(req_cnt), 32'(c0 + 1));
  endtask

  // Monitor: IF/ID samples the presented instruction on every unstalled edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_samples++;
          chk(!stall[1] && if_inst == e.inst, "sample_inst", if_inst, e.inst);
          chk(if_pc == e.pc, "sample_pc", if_pc, e.pc);
        end else if (!stall[1]) begin
          chk(if_inst == 32'h0, "spurious", if_inst, 32'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk(mem_req == 1'b0, "rst_mem_req", 32'(mem_req), 32'h0);
    chk(mem_addr == 32'h0, "rst_mem_addr", mem_addr, 32'h0);
    chk(if_pc == 32'h0, "rst_if_pc", if_pc, 32'h0);
    chk(if_inst == 32'h0, "rst_if_inst", if_inst, 32'h0);
    chk(stallreq_if == 1'b0, "rst_stallreq", 32'(stallreq_if), 32'h0);
    rst = 1'b0;
    step();
    chk(req_cnt == 1, "first_req", 32'(req_cnt), 32'h1);

    // Straight-line fetch of 0x13 with one-cycle ack latency.
    repeat (10) step();

    // Held instruction under IF/ID stall.
    f_hold = 3;
    repeat (8) step();
    f_hold = 0;

    // EX redirect mid-WAIT, ack two cycles later.
    f_lat = 3;
    wait_req();
    f_ex = 1; f_ex_t = 32'h0000_0103;
    step();
    f_ex = 0;
    wait_req();
    chk(last_req_addr == 32'h0000_0100, "redir_ex", last_req_addr, 32'h0000_0100);

    // EX and ID together: EX wins.
    f_ex = 1; f_ex_t = 32'h0000_0200; f_id = 1; f_id_t = 32'h0000_0300;
    step();
    f_ex = 0; f_id = 0;
    wait_req();
    chk(last_req_addr == 32'h0000_0200, "redir_both", last_req_addr, 32'h0000_0200);

    // Wrap from the top of the address space.
    f_ex = 1; f_ex_t = 32'hFFFF_FFFE;
    step();
    f_ex = 0; f_lat = 1;
    wait_req();
    chk(last_req_addr == 32'hFFFF_FFFC, "redir_top", last_req_addr, 32'hFFFF_FFFC);
    wait_req();
    chk(last_req_addr == 32'h0000_0000, "pc_wrap", last_req_addr, 32'h0000_0000);

    // Random traffic.
    rnd = 1;
    repeat (1500) step();
    rnd = 0;
    repeat (12) step();

    // Reset in the middle of an outstanding request, stray ack right after release.
    no_ack = 1;
    wait_req();
    step();
    #2 rst = 1'b1;
    #1;
    chk(mem_req == 1'b0 && stallreq_if == 1'b0, "midrst_req", 32'(mem_req), 32'h0);
    chk(if_pc == 32'h0 && if_inst == 32'h0, "midrst_out", if_inst, 32'h0);
    out_v = 0; pend_v = 0; hold_cnt = 0; just_acked = 0; m_pc = RESET_PC;
    no_ack = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    ex_b_flag = 1'b0; id_b_flag = 1'b0; stall = '0;
    c0 = req_cnt;
    step();
    chk(req_cnt == c0 + 1 && last_req_addr == RESET_PC, "post_rst_req", last_req_addr, RESET_PC);
    repeat (10) step();

    @(negedge clk); #1;
    chk(exp_q.size() == 0, "queue_drain", 32'(exp_q.size()), 32'h0);
    chk(n_samples >= 50, "sample_count", 32'(n_samples), 32'd50);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
